pbd_scan_driver: RTL and testbench

//  Upstream driver for the PBD 1-to-2^SEL_W decoder stage: generates the select (a) and enable (e) inputs.

---
 rtl/pbd_pkg.sv | 14 +
 rtl/pbd_phase_timer.sv | 31 +++
 rtl/pbd_scan_driver.sv | 139 +++++++++++++
 tb/tb_pbd_scan_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pbd_pkg.sv
// Shared types and helpers for the PBD decoder scan driver.
package pbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } pbd_state_t;

  function automatic int unsigned num_out(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/pbd_phase_timer.sv
// Phase counter: counts up from 0 and flags the last cycle of a phase
// whose length is limit_i; hold freezes it, clr restarts it.
module pbd_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (clr_i) cnt_d = '0;
      else       cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit_i - CNT_W'(1));

endmodule

// File: rtl/pbd_scan_driver.sv
// Drives select/enable of a 1-to-2**SEL_W decoder: each select gets a
// DWELL-cycle enable followed by GAP idle cycles, single-shot or looping.
module pbd_scan_driver
  import pbd_pkg::*;
#(
  parameter int unsigned SEL_W = 1,
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic             hold,
  output logic [SEL_W-1:0] a,
  output logic             e,
  output logic             busy,
  output logic             sweep_done
);

  localparam int unsigned      NUM_OUT = num_out(SEL_W);
  localparam logic [SEL_W-1:0] A_MAX   = SEL_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] DWELL_L = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] GAP_L   = CNT_W'(GAP);

  pbd_state_t       state_q, state_d;
  logic [SEL_W-1:0] a_q, a_d;
  logic             e_q, e_d;
  logic             done_q, done_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cont_q, cont_d;
  logic             clr;
  logic             tc;
  logic             last;
  logic [CNT_W-1:0] limit;

  assign busy  = (state_q != ST_IDLE);
  assign limit = (state_q == ST_GAP) ? GAP_L : DWELL_L;

  pbd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .hold_i  (hold),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    e_d         = e_q;
    done_d      = 1'b0;
    cont_d      = cont_q;
    clr         = 1'b0;
    stop_pend_d = stop_pend_q | (stop & busy);
    last        = ((a_q == A_MAX) && !cont_q) || stop_pend_q;

    // hold freezes everything except stop latching; done stays low
    if (!hold) begin
      unique case (state_q)
        ST_IDLE: begin
          clr         = 1'b1;
          stop_pend_d = 1'b0;
          if (start) begin
            state_d = ST_DRIVE;
            a_d     = '0;
            e_d     = 1'b1;
            cont_d  = continuous;
          end
        end
        ST_DRIVE: begin
          if (tc) begin
            clr = 1'b1;
            if (last) begin
              state_d     = ST_IDLE;
              a_d         = '0;
              e_d         = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (GAP > 0) begin
              state_d = ST_GAP;
              e_d     = 1'b0;
            end else begin
              a_d = a_q + SEL_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tc) begin
            clr = 1'b1;
            if (stop_pend_q) begin
              state_d     = ST_IDLE;
              a_d         = '0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else begin
              state_d = ST_DRIVE;
              a_d     = a_q + SEL_W'(1);
              e_d     = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          a_d     = '0;
          e_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      e_q         <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      e_q         <= e_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      cont_q      <= cont_d;
    end
  end

  assign a          = a_q;
  assign e          = e_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_pbd_scan_driver.sv
// Directed bench for pbd_scan_driver across three parameter sets.
module tb_pbd_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, start = 1'b0, continuous = 1'b0, stop = 1'b0, hold = 1'b0;

  logic       a_A, e_A, busy_A, done_A;
  logic       a_B, e_B, busy_B, done_B;
  logic [1:0] a_C;
  logic       e_C, busy_C, done_C;

  int n_checks = 0;
  int n_fail   = 0;
  int which    = 0;

  pbd_scan_driver #(.SEL_W(1), .DWELL(4), .GAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop), .hold(hold),
    .a(a_A), .e(e_A), .busy(busy_A), .sweep_done(done_A));

  pbd_scan_driver #(.SEL_W(1), .DWELL(4), .GAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop), .hold(hold),
    .a(a_B), .e(e_B), .busy(busy_B), .sweep_done(done_B));

  pbd_scan_driver #(.SEL_W(2), .DWELL(1), .GAP(2), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop), .hold(hold),
    .a(a_C), .e(e_C), .busy(busy_C), .sweep_done(done_C));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int ea, input bit ee, input bit eb, input bit ed);
    logic [1:0] oa;
    logic oe, ob, od;
    case (which)
      0:       begin oa = {1'b0, a_A}; oe = e_A; ob = busy_A; od = done_A; end
      1:       begin oa = {1'b0, a_B}; oe = e_B; ob = busy_B; od = done_B; end
      default: begin oa = a_C;         oe = e_C; ob = busy_C; od = done_C; end
    endcase
    check({tag, ".a"},    32'(oa), 32'(ea));
    check({tag, ".e"},    32'(oe), 32'(ee));
    check({tag, ".busy"}, 32'(ob), 32'(eb));
    check({tag, ".done"}, 32'(od), 32'(ed));
  endtask

  task automatic expect_seq(input string tag, input int n, input int ea,
                            input bit ee, input bit eb, input bit ed);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out($sformatf("%s[%0d]", tag, i), ea, ee, eb, ed);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; hold = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input bit cont);
    start = 1'b1; continuous = cont;
    step();
    start = 1'b0; continuous = 1'b0;
  endtask

  // Expected trace of a full single sweep on dut_a, starting on the cycle after the start edge.
  task automatic full_sweep_a(input string tag);
    chk_out({tag, "_d0s"}, 0, 1, 1, 0);
    expect_seq({tag, "_d0"}, 3, 0, 1, 1, 0);
    expect_seq({tag, "_gap"}, 1, 0, 0, 1, 0);
    expect_seq({tag, "_d1"}, 4, 1, 1, 1, 0);
    expect_seq({tag, "_done"}, 1, 0, 0, 0, 1);
    expect_seq({tag, "_idle"}, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // 1: reset state and single sweep
    which = 0;
    do_reset();
    chk_out("rst", 0, 0, 0, 0);
    expect_seq("idle", 1, 0, 0, 0, 0);
    pulse_start(1'b0);
    full_sweep_a("t1");

    // 2: continuous with GAP=0, stop ends after current dwell
    which = 1;
    do_reset();
    pulse_start(1'b1);
    chk_out("t2_a0s", 0, 1, 1, 0);
    expect_seq("t2_a0", 3, 0, 1, 1, 0);
    expect_seq("t2_a1", 4, 1, 1, 1, 0);
    expect_seq("t2_a0w", 4, 0, 1, 1, 0);
    expect_seq("t2_a1b", 1, 1, 1, 1, 0);
    stop = 1'b1;
    expect_seq("t2_stop", 1, 1, 1, 1, 0);
    stop = 1'b0;
    expect_seq("t2_fin", 2, 1, 1, 1, 0);
    expect_seq("t2_done", 1, 0, 0, 0, 1);
    expect_seq("t2_idle", 1, 0, 0, 0, 0);

    // 3: stop in 2nd cycle of a=0 dwell
    which = 0;
    do_reset();
    pulse_start(1'b0);
    chk_out("t3_c0", 0, 1, 1, 0);
    expect_seq("t3_c1", 1, 0, 1, 1, 0);
    stop = 1'b1;
    expect_seq("t3_c2", 1, 0, 1, 1, 0);
    stop = 1'b0;
    expect_seq("t3_c3", 1, 0, 1, 1, 0);
    expect_seq("t3_done", 1, 0, 0, 0, 1);
    expect_seq("t3_idle", 2, 0, 0, 0, 0);

    // 4: hold for 3 cycles mid-dwell, stop latched during hold
    do_reset();
    pulse_start(1'b0);
    chk_out("t4_c0", 0, 1, 1, 0);
    expect_seq("t4_c1", 1, 0, 1, 1, 0);
    hold = 1'b1;
    expect_seq("t4_h0", 1, 0, 1, 1, 0);
    stop = 1'b1;
    expect_seq("t4_h1", 1, 0, 1, 1, 0);
    stop = 1'b0;
    expect_seq("t4_h2", 1, 0, 1, 1, 0);
    hold = 1'b0;
    expect_seq("t4_c23", 2, 0, 1, 1, 0);
    expect_seq("t4_done", 1, 0, 0, 0, 1);
    expect_seq("t4_idle", 1, 0, 0, 0, 0);

    // 5: start while busy ignored, reset mid-GAP drops pending stop
    do_reset();
    pulse_start(1'b0);
    chk_out("t5_c0", 0, 1, 1, 0);
    start = 1'b1;
    expect_seq("t5_c12", 2, 0, 1, 1, 0);
    start = 1'b0;
    expect_seq("t5_c3", 1, 0, 1, 1, 0);
    expect_seq("t5_gap", 1, 0, 0, 1, 0);
    rst = 1'b1; stop = 1'b1;
    step();
    rst = 1'b0; stop = 1'b0;
    chk_out("t5_rst", 0, 0, 0, 0);
    expect_seq("t5_idle", 2, 0, 0, 0, 0);
    pulse_start(1'b0);
    full_sweep_a("t5r");
    hold = 1'b1; start = 1'b1;
    expect_seq("t5_hstart", 1, 0, 0, 0, 0);
    hold = 1'b0; start = 1'b0;
    expect_seq("t5_hidle", 1, 0, 0, 0, 0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    full_sweep_a("t5ss");

    // 6: SEL_W=2, DWELL=1, GAP=2
    which = 2;
    do_reset();
    pulse_start(1'b0);
    chk_out("t6_a0", 0, 1, 1, 0);
    for (int k = 1; k < 4; k++) begin
      expect_seq($sformatf("t6_gap%0d", k), 2, k - 1, 0, 1, 0);
      expect_seq($sformatf("t6_a%0d", k), 1, k, 1, 1, 0);
    end
    expect_seq("t6_done", 1, 0, 0, 0, 1);
    expect_seq("t6_idle", 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
